// File: rtl/usb_burst_read_gate.sv
// usb_burst_read_gate: FX2 read-burst gate and packetiser.
// Accepts words from the GPIF read bus while RD is high, caps each burst at
// BURST_WORDS, honours downstream back-pressure, and forwards accepted words
// to the packet FIFO one cycle after capture with sop/eop packet markers.
// A burst that ends mid-packet sets a sticky truncation flag.
//
// Handshake: a word on usbdata is transferred in every cycle where rdreq=1
// (rdreq is the combinational accept strobe back to the FX2 side). On the
// FIFO side a word is delivered in every cycle where wrreq=1; there is no
// ready, fifo_afull is expected to assert early enough to absorb in-flight
// words.
module usb_burst_read_gate #(
  parameter int WIDTH       = 16,
  parameter int BURST_WORDS = 256,
  parameter int PKT_WORDS   = 256,
  localparam int CNT_W      = $clog2(BURST_WORDS + 1)
) (
  input  logic             usbclk,
  input  logic             bus_reset,
  input  logic             RD,
  input  logic [WIDTH-1:0] usbdata,
  input  logic             fifo_afull,
  input  logic             clr_err,
  output logic             rdreq,
  output logic             wrreq,
  output logic [WIDTH-1:0] wrdata,
  output logic             sop,
  output logic             eop,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             burst_done,
  output logic             err_trunc
);

  localparam int PCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_WORDS - 1);
  localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(PKT_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    CAPPED = 2'd2
  } state_t;

  state_t            state;
  logic [PCNT_W-1:0] pcnt;

  // Capture stage: holds the word accepted at the previous edge.
  logic              cap_valid;
  logic [WIDTH-1:0]  cap_data;
  logic              cap_sop;
  logic              cap_eop;
  logic              cap_done;

  logic              last_word;
  logic              trunc;

  // Accept strobe; never asserted during reset or once the burst is capped.
  assign rdreq     = RD & ~bus_reset & (state != CAPPED) & ~fifo_afull;
  assign last_word = (burst_cnt == LAST_CNT);
  // RD falling while a packet is partially transferred.
  assign trunc     = ~RD & (pcnt != '0);

  // Burst state machine with burst and packet counters.
  always_ff @(posedge usbclk) begin
    if (bus_reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      pcnt      <= '0;
    end else if (!RD) begin
      state     <= IDLE;
      burst_cnt <= '0;
      if (trunc) begin
        pcnt <= '0;
      end
    end else if (rdreq) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
      pcnt      <= (pcnt == LAST_PCNT) ? '0 : pcnt + PCNT_W'(1);
      state     <= last_word ? CAPPED : XFER;
    end else if (state == IDLE) begin
      // RD high but stalled by back-pressure: the burst has still started.
      state <= XFER;
    end
  end

  // Sticky truncation flag; a new truncation beats a simultaneous clear.
  always_ff @(posedge usbclk) begin
    if (bus_reset) begin
      err_trunc <= 1'b0;
    end else if (trunc) begin
      err_trunc <= 1'b1;
    end else if (clr_err) begin
      err_trunc <= 1'b0;
    end
  end

  // Capture stage and output register; reset squashes any word in flight.
  always_ff @(posedge usbclk) begin
    if (bus_reset) begin
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      cap_sop    <= 1'b0;
      cap_eop    <= 1'b0;
      cap_done   <= 1'b0;
      wrreq      <= 1'b0;
      wrdata     <= '0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      cap_valid <= rdreq;
      if (rdreq) begin
        cap_data <= usbdata;
      end
      cap_sop    <= rdreq & (pcnt == '0);
      cap_eop    <= rdreq & (pcnt == LAST_PCNT);
      cap_done   <= rdreq & last_word;
      wrreq      <= cap_valid;
      if (cap_valid) begin
        wrdata <= cap_data;
      end
      sop        <= cap_sop;
      eop        <= cap_eop;
      burst_done <= cap_done;
    end
  end

endmodule

// File: tb/tb_usb_burst_read_gate.sv
// Bench for usb_burst_read_gate: directed bursts followed by random traffic,
// checked against a word-count model through an expected-word queue.
module tb_usb_burst_read_gate;

  localparam int W  = 16;
  localparam int BW = 64;
  localparam int PW = 16;
  localparam int CW = $clog2(BW + 1);
  localparam int EW = W + 3 + 16;

  // Clock/reset and DUT signals
  logic          usbclk     = 1'b0;
  logic          bus_reset  = 1'b1;
  logic          rd         = 1'b0;
  logic [W-1:0]  usbdata    = '0;
  logic          fifo_afull = 1'b0;
  logic          clr_err    = 1'b0;
  logic          rdreq;
  logic          wrreq;
  logic [W-1:0]  wrdata;
  logic          sop;
  logic          eop;
  logic [CW-1:0] burst_cnt;
  logic          burst_done;
  logic          err_trunc;

  always #5 usbclk = ~usbclk;

  usb_burst_read_gate #(
    .WIDTH(W),
    .BURST_WORDS(BW),
    .PKT_WORDS(PW)
  ) dut (
    .usbclk(usbclk),
    .bus_reset(bus_reset),
    .RD(rd),
    .usbdata(usbdata),
    .fifo_afull(fifo_afull),
    .clr_err(clr_err),
    .rdreq(rdreq),
    .wrreq(wrreq),
    .wrdata(wrdata),
    .sop(sop),
    .eop(eop),
    .burst_cnt(burst_cnt),
    .burst_done(burst_done),
    .err_trunc(err_trunc)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  // Entry: {accept_edge[15:0], done, eop, sop, data}
  logic [EW-1:0] exp_q[$];

  // Reference model: words taken this burst, words since the packet stream
  // (re)started, sticky error, and whether the previous edge took a word.
  int m_b   = 0;
  int m_k   = 0;
  int m_cyc = 0;
  bit m_err = 1'b0;
  bit m_last = 1'b0;
  bit m_acc;
  bit mon_en = 1'b0;

  function automatic bit exp_rdreq();
    return rd && !bus_reset && (m_b < BW) && !fifo_afull;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model update at each active edge from the inputs held across it.
  always @(posedge usbclk) begin
    m_acc = exp_rdreq();
    m_cyc++;
    if (bus_reset) begin
      // The word taken just before reset never reaches the FIFO.
      if (m_last && exp_q.size() > 0) void'(exp_q.pop_back());
      m_b = 0;
      m_k = 0;
      m_err = 1'b0;
      m_last = 1'b0;
      mon_en = 1'b1;
    end else begin
      if (m_acc) begin
        exp_q.push_back({16'(m_cyc), (m_b + 1 == BW), ((m_k % PW) == PW - 1),
                         ((m_k % PW) == 0), usbdata});
        m_b++;
        m_k++;
      end
      if (!rd) begin
        if ((m_k % PW) != 0) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        m_b = 0;
        m_k = 0;
      end else if (clr_err) begin
        m_err = 1'b0;
      end
      m_last = m_acc;
    end
  end

  // Monitor: compares status every cycle and pops one entry per wrreq.
  always @(negedge usbclk) begin
    logic [EW-1:0] e;
    logic [15:0]   lat;
    if (mon_en) begin
      check("rdreq", 32'(rdreq), 32'(exp_rdreq()));
      check("burst_cnt", 32'(burst_cnt), 32'(m_b));
      check("err_trunc", 32'(err_trunc), 32'(m_err));
      if (wrreq) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wrreq_unexpected actual 1 required 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          lat = 16'(m_cyc) - e[EW-1:W+3];
          check("wrdata", 32'(wrdata), 32'(e[W-1:0]));
          check("sop", 32'(sop), 32'(e[W]));
          check("eop", 32'(eop), 32'(e[W+1]));
          check("burst_done", 32'(burst_done), 32'(e[W+2]));
          check("latency", 32'(lat), 32'd1);
        end
      end else begin
        check("burst_done_idle", 32'(burst_done), 32'd0);
      end
    end
  end

  // Driver: inputs change shortly after each active edge.
  task automatic drive(input bit r, input bit af, input bit c, input bit rs, input int n);
    repeat (n) begin
      @(posedge usbclk);
      #2;
      rd = r;
      fifo_afull = af;
      clr_err = c;
      bus_reset = rs;
      usbdata = W'($urandom);
    end
  endtask

  initial begin
    bit r;
    drive(0, 0, 0, 1, 3);
    drive(0, 0, 0, 0, 2);
    // Full burst with RD held well past the cap.
    drive(1, 0, 0, 0, BW + 20);
    drive(0, 0, 0, 0, 3);
    // Back-pressure window mid-burst.
    drive(1, 0, 0, 0, 20);
    drive(1, 1, 0, 0, 10);
    drive(1, 0, 0, 0, BW);
    drive(0, 0, 0, 0, 3);
    // Early drop mid-packet, then new burst, then clear.
    drive(1, 0, 0, 0, PW + 6);
    drive(0, 0, 0, 0, 3);
    drive(1, 0, 0, 0, 5);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 2);
    drive(1, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 2);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 2);
    // Drop at an exact packet boundary is not an error.
    drive(1, 0, 0, 0, PW);
    drive(0, 0, 0, 0, 2);
    // Reset in the middle of a burst with RD still high.
    drive(1, 0, 0, 0, 30);
    drive(1, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 10);
    drive(0, 0, 0, 0, 2);
    // Single-cycle RD pulses.
    repeat (6) begin
      drive(1, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
    end
    // Random traffic.
    r = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) r = ~r;
      drive(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 299) == 0), 1);
    end
    // Drain and confirm nothing is left outstanding.
    drive(0, 0, 0, 0, 8);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
